grant_stream_mux: RTL and testbench

Packet-aware stream multiplexer that sits directly downstream of the `arbiter` block in the AXI4 mux testbench path. It drives the arbiter's `request`/`acknowledge` inputs from the `PORTS` input streams. It consumes the registered `grant`/`grant_valid`/`grant_encoded` outputs and forwards the granted port's beats, tagged with the source index, through a two-entry skid buffer. The arbiter must be instantiated with `ARB_BLOCK=1` and `ARB_BLOCK_ACK=1`, so a grant is held for a whole packet.

---
 rtl/grant_stream_mux.sv | 185 ++++++++++++++++++
 tb/tb_grant_stream_mux.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grant_stream_mux.sv
// grant_stream_mux
//
// Packet-aware stream multiplexer that sits directly downstream of a
// round-robin arbiter configured to hold a grant for a whole packet (grant
// released only by acknowledge). It converts the PORTS input streams into
// arbiter requests and forwards the granted port's beats, tagged with the
// source index, through a two-entry skid buffer. m_ready is registered
// before it reaches s_ready, so no combinational path runs from the output
// handshake back to the inputs.
//
// PORTS must be at least 2. SEL_WIDTH is derived from PORTS and should not
// be overridden.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   s_valid/s_ready    per-port input handshake
//   s_data/s_last/     per-port beat payload; port i data occupies
//   s_user             s_data[i*DATA_WIDTH +: DATA_WIDTH]
//   m_valid/m_ready    output handshake
//   m_data/m_last/     output beat payload
//   m_user
//   m_sel              source port index of the current output beat
//   arb_request        to arbiter request
//   arb_acknowledge    to arbiter acknowledge (one pulse on accepted last beat)
//   arb_grant          from arbiter grant (one-hot or zero)
//   arb_grant_valid    from arbiter grant_valid
//   arb_grant_encoded  from arbiter grant_encoded

module grant_stream_mux #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int SEL_WIDTH  = $clog2(PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS-1:0]            s_valid,
    output logic [PORTS-1:0]            s_ready,
    input  logic [PORTS*DATA_WIDTH-1:0] s_data,
    input  logic [PORTS-1:0]            s_last,
    input  logic [PORTS*USER_WIDTH-1:0] s_user,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [DATA_WIDTH-1:0]       m_data,
    output logic                        m_last,
    output logic [USER_WIDTH-1:0]       m_user,
    output logic [SEL_WIDTH-1:0]        m_sel,
    output logic [PORTS-1:0]            arb_request,
    output logic [PORTS-1:0]            arb_acknowledge,
    input  logic [PORTS-1:0]            arb_grant,
    input  logic                        arb_grant_valid,
    input  logic [SEL_WIDTH-1:0]        arb_grant_encoded
);

    if (PORTS < 2) begin : g_bad_ports
        $error("grant_stream_mux: PORTS must be at least 2");
    end

    // Output (main) register and skid (temp) register
    logic                  m_valid_reg;
    logic [DATA_WIDTH-1:0] m_data_reg;
    logic                  m_last_reg;
    logic [USER_WIDTH-1:0] m_user_reg;
    logic [SEL_WIDTH-1:0]  m_sel_reg;

    logic                  temp_valid_reg;
    logic [DATA_WIDTH-1:0] temp_data_reg;
    logic                  temp_last_reg;
    logic [USER_WIDTH-1:0] temp_user_reg;
    logic [SEL_WIDTH-1:0]  temp_sel_reg;

    logic                  ready_int_reg;

    // Selected input beat
    logic [PORTS-1:0]      s_accept;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic [USER_WIDTH-1:0] in_user;

    // Skid-buffer control
    logic ready_int_early;
    logic m_valid_next;
    logic temp_valid_next;
    logic store_in_to_main;
    logic store_in_to_temp;
    logic store_temp_to_main;

    // Only the granted port can see ready, and only while the skid buffer
    // has room. A finishing port drops its request in the acknowledge cycle
    // so the arbiter does not immediately re-grant it.
    assign s_ready         = arb_grant & {PORTS{arb_grant_valid & ready_int_reg}};
    assign s_accept        = s_valid & s_ready;
    assign in_valid        = |s_accept;
    assign arb_acknowledge = arb_grant & s_accept & s_last;
    assign arb_request     = s_valid & ~arb_acknowledge;

    // Payload mux driven by the encoded grant. Defaults keep the mux free
    // of latches when the encoded index is out of range.
    always_comb begin
        in_data = '0;
        in_last = 1'b0;
        in_user = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (arb_grant_encoded == SEL_WIDTH'(i)) begin
                in_data = s_data[i*DATA_WIDTH +: DATA_WIDTH];
                in_last = s_last[i];
                in_user = s_user[i*USER_WIDTH +: USER_WIDTH];
            end
        end
    end

    // Skid-buffer steering. While ready_int_reg is high a beat may arrive;
    // it lands in main if main is free or draining this cycle, otherwise in
    // temp. While ready_int_reg is low nothing arrives, and a draining main
    // is refilled from temp. Input ready is dropped one cycle after the
    // buffer would otherwise overflow, which is what temp absorbs.
    always_comb begin
        ready_int_early    = m_ready | (~temp_valid_reg & (~m_valid_reg | ~in_valid));
        m_valid_next       = m_valid_reg;
        temp_valid_next    = temp_valid_reg;
        store_in_to_main   = 1'b0;
        store_in_to_temp   = 1'b0;
        store_temp_to_main = 1'b0;
        if (ready_int_reg) begin
            if (m_ready | ~m_valid_reg) begin
                m_valid_next     = in_valid;
                store_in_to_main = in_valid;
            end else begin
                temp_valid_next  = in_valid;
                store_in_to_temp = in_valid;
            end
        end else if (m_ready) begin
            m_valid_next       = temp_valid_reg;
            temp_valid_next    = 1'b0;
            store_temp_to_main = temp_valid_reg;
        end
    end

    // Register update. Reset discards any buffered beats and clears ready so
    // no input is accepted until the buffer state is known to be empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_reg    <= 1'b0;
            m_data_reg     <= '0;
            m_last_reg     <= 1'b0;
            m_user_reg     <= '0;
            m_sel_reg      <= '0;
            temp_valid_reg <= 1'b0;
            temp_data_reg  <= '0;
            temp_last_reg  <= 1'b0;
            temp_user_reg  <= '0;
            temp_sel_reg   <= '0;
            ready_int_reg  <= 1'b0;
        end else begin
            m_valid_reg    <= m_valid_next;
            temp_valid_reg <= temp_valid_next;
            ready_int_reg  <= ready_int_early;
            if (store_in_to_main) begin
                m_data_reg <= in_data;
                m_last_reg <= in_last;
                m_user_reg <= in_user;
                m_sel_reg  <= arb_grant_encoded;
            end else if (store_temp_to_main) begin
                m_data_reg <= temp_data_reg;
                m_last_reg <= temp_last_reg;
                m_user_reg <= temp_user_reg;
                m_sel_reg  <= temp_sel_reg;
            end
            if (store_in_to_temp) begin
                temp_data_reg <= in_data;
                temp_last_reg <= in_last;
                temp_user_reg <= in_user;
                temp_sel_reg  <= arb_grant_encoded;
            end
        end
    end

    assign m_valid = m_valid_reg;
    assign m_data  = m_data_reg;
    assign m_last  = m_last_reg;
    assign m_user  = m_user_reg;
    assign m_sel   = m_sel_reg;

endmodule

// File: tb/tb_grant_stream_mux.sv
// tb_grant_stream_mux
//
// Directed testbench for grant_stream_mux. A small round-robin arbiter
// model (grant held until acknowledge, search starts after the last granted
// port) closes the request/grant loop. Per-port packet sources present beats
// from simple tables; every accepted and delivered beat is logged and
// compared against hand-derived port orders, data values and cycle numbers.

module tb_grant_stream_mux;

    localparam int PORTS      = 4;
    localparam int DATA_WIDTH = 64;
    localparam int USER_WIDTH = 1;
    localparam int SEL_WIDTH  = 2;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [PORTS-1:0]            s_valid;
    logic [PORTS-1:0]            s_ready;
    logic [PORTS*DATA_WIDTH-1:0] s_data;
    logic [PORTS-1:0]            s_last;
    logic [PORTS*USER_WIDTH-1:0] s_user;
    logic                        m_valid;
    logic                        m_ready;
    logic [DATA_WIDTH-1:0]       m_data;
    logic                        m_last;
    logic [USER_WIDTH-1:0]       m_user;
    logic [SEL_WIDTH-1:0]        m_sel;
    logic [PORTS-1:0]            arb_request;
    logic [PORTS-1:0]            arb_acknowledge;
    logic [PORTS-1:0]            arb_grant;
    logic                        arb_grant_valid;
    logic [SEL_WIDTH-1:0]        arb_grant_encoded;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    grant_stream_mux #(
        .PORTS      (PORTS),
        .DATA_WIDTH (DATA_WIDTH),
        .USER_WIDTH (USER_WIDTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .s_data            (s_data),
        .s_last            (s_last),
        .s_user            (s_user),
        .m_valid           (m_valid),
        .m_ready           (m_ready),
        .m_data            (m_data),
        .m_last            (m_last),
        .m_user            (m_user),
        .m_sel             (m_sel),
        .arb_request       (arb_request),
        .arb_acknowledge   (arb_acknowledge),
        .arb_grant         (arb_grant),
        .arb_grant_valid   (arb_grant_valid),
        .arb_grant_encoded (arb_grant_encoded)
    );

    // Arbiter model: registered grant, held until the granted port
    // acknowledges, then re-arbitrated round robin starting after the port
    // that was granted last.
    int arb_last;
    always @(posedge clk) begin : arb_model
        bit found;
        int pick;
        int idx;
        if (rst) begin
            arb_grant         <= '0;
            arb_grant_valid   <= 1'b0;
            arb_grant_encoded <= '0;
            arb_last          <= PORTS - 1;
        end else if (!(arb_grant_valid && ((arb_grant & arb_acknowledge) == '0))) begin
            found = 1'b0;
            pick  = 0;
            for (int k = 1; k <= PORTS; k++) begin
                idx = (arb_last + k) % PORTS;
                if (!found && arb_request[idx]) begin
                    found = 1'b1;
                    pick  = idx;
                end
            end
            if (found) begin
                arb_grant         <= PORTS'(1) << pick;
                arb_grant_valid   <= 1'b1;
                arb_grant_encoded <= SEL_WIDTH'(pick);
                arb_last          <= pick;
            end else begin
                arb_grant       <= '0;
                arb_grant_valid <= 1'b0;
            end
        end
    end

    // Source tables and logs
    logic [DATA_WIDTH-1:0] src_base [PORTS];
    int src_cnt [PORTS];
    int src_idx [PORTS];
    int src_pkt_len [PORTS];
    int gap_at [PORTS];
    int gap_len [PORTS];
    int gap_cnt [PORTS];
    int first_ready [PORTS];
    bit m_ready_pat[$];

    logic [DATA_WIDTH-1:0] out_data[$];
    logic [SEL_WIDTH-1:0]  out_sel[$];
    bit                    out_last[$];
    logic [USER_WIDTH-1:0] out_user[$];
    int out_cyc[$];
    int acc_port[$];
    int acc_cyc[$];
    int ack_port[$];
    int ack_cyc[$];

    int cyc, occ, bad_occ, bad_hold, bad_onehot, bad_ack;
    int stretch_acc, max_extra;
    bit stretch_valid, prev_ready;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clearLogs();
        out_data.delete(); out_sel.delete(); out_last.delete(); out_user.delete();
        out_cyc.delete(); acc_port.delete(); acc_cyc.delete();
        ack_port.delete(); ack_cyc.delete(); m_ready_pat.delete();
        for (int p = 0; p < PORTS; p++) begin
            src_cnt[p]     = 0;
            src_idx[p]     = 0;
            src_pkt_len[p] = 1;
            gap_at[p]      = -1;
            gap_len[p]     = 0;
            gap_cnt[p]     = 0;
            first_ready[p] = -1;
        end
        s_valid = '0;
        s_last  = '0;
        cyc = 0; occ = 0; bad_occ = 0; bad_hold = 0; bad_onehot = 0; bad_ack = 0;
        stretch_acc = 0; max_extra = 0; stretch_valid = 1'b0; prev_ready = 1'b1;
    endtask

    task automatic loadPort(input int p, input logic [DATA_WIDTH-1:0] base, input int cnt,
                            input int pkt_len, input int g_at, input int g_len);
        src_base[p]    = base;
        src_cnt[p]     = cnt;
        src_pkt_len[p] = pkt_len;
        gap_at[p]      = g_at;
        gap_len[p]     = g_len;
    endtask

    // Runs n cycles: drive sources at the falling edge, observe 1 time unit
    // later, then advance sources on the beats that were accepted.
    task automatic applyStimulus(input int n);
        logic [PORTS-1:0]      acc;
        logic [DATA_WIDTH-1:0] d;
        bit                    v;
        for (int c = 0; c < n; c++) begin
            for (int p = 0; p < PORTS; p++) begin
                v = (src_idx[p] < src_cnt[p]) &&
                    !(src_idx[p] == gap_at[p] && gap_cnt[p] < gap_len[p]);
                d = src_base[p] + DATA_WIDTH'(src_idx[p]);
                s_valid[p] = v;
                s_data[p*DATA_WIDTH +: DATA_WIDTH] = d;
                s_last[p]  = ((src_idx[p] + 1) % src_pkt_len[p]) == 0;
                s_user[p]  = d[0];
            end
            m_ready = (m_ready_pat.size() > 0) ? m_ready_pat.pop_front() : 1'b1;
            #1;
            acc = s_valid & s_ready;
            if ($countones(s_ready) > 1) bad_onehot++;
            if (occ > 0 && !m_valid) bad_hold++;
            if (occ > 2) bad_occ++;
            if (!m_ready) begin
                if (prev_ready) begin
                    stretch_valid = m_valid;
                    stretch_acc   = 0;
                end
                stretch_acc += $countones(acc);
                if (stretch_valid && stretch_acc > max_extra) max_extra = stretch_acc;
            end
            prev_ready = m_ready;
            for (int p = 0; p < PORTS; p++) begin
                if (s_ready[p] && first_ready[p] < 0) first_ready[p] = cyc;
                if (acc[p]) begin
                    acc_port.push_back(p);
                    acc_cyc.push_back(cyc);
                end
                if (arb_acknowledge[p] != (acc[p] && s_last[p])) bad_ack++;
                if (arb_acknowledge[p]) begin
                    ack_port.push_back(p);
                    ack_cyc.push_back(cyc);
                end
            end
            if (m_valid && m_ready) begin
                out_data.push_back(m_data);
                out_sel.push_back(m_sel);
                out_last.push_back(m_last);
                out_user.push_back(m_user);
                out_cyc.push_back(cyc);
                occ--;
            end
            occ += $countones(acc);
            @(negedge clk);
            cyc++;
            for (int p = 0; p < PORTS; p++) begin
                if (acc[p]) begin
                    src_idx[p]++;
                    gap_cnt[p] = 0;
                end else if (!s_valid[p] && src_idx[p] < src_cnt[p]) begin
                    gap_cnt[p]++;
                end
            end
        end
    endtask

    // Compares the delivered beats against an expected per-beat port order;
    // data, last and user follow from each port's table.
    task automatic checkStream(input string tag, input int exp_port[$]);
        int seen [PORTS];
        int p, k;
        logic [DATA_WIDTH-1:0] exp_data;
        bit exp_last;
        for (int i = 0; i < PORTS; i++) seen[i] = 0;
        checkOutput({tag, "_beats"}, 64'(out_data.size()), 64'(exp_port.size()));
        for (int i = 0; i < exp_port.size() && i < out_data.size(); i++) begin
            p = exp_port[i];
            k = seen[p];
            seen[p]++;
            exp_data = src_base[p] + DATA_WIDTH'(k);
            exp_last = ((k + 1) % src_pkt_len[p]) == 0;
            checkOutput($sformatf("%s_data%0d", tag, i), out_data[i], exp_data);
            checkOutput($sformatf("%s_sel_last_user%0d", tag, i),
                        64'({out_sel[i], out_last[i], out_user[i]}),
                        64'({SEL_WIDTH'(p), exp_last, exp_data[0]}));
        end
    endtask

    task automatic checkInvariants(input string tag);
        checkOutput({tag, "_ready_onehot_viol"}, 64'(bad_onehot), 64'(0));
        checkOutput({tag, "_ack_viol"}, 64'(bad_ack), 64'(0));
        checkOutput({tag, "_valid_hold_viol"}, 64'(bad_hold), 64'(0));
        checkOutput({tag, "_occupancy_viol"}, 64'(bad_occ), 64'(0));
    endtask

    task automatic checkAckCycles(input string tag, input int exp_cyc[$]);
        checkOutput({tag, "_ack_count"}, 64'(ack_cyc.size()), 64'(exp_cyc.size()));
        for (int i = 0; i < exp_cyc.size() && i < ack_cyc.size(); i++)
            checkOutput($sformatf("%s_ack_cyc%0d", tag, i), 64'(ack_cyc[i]), 64'(exp_cyc[i]));
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = '0;
        s_data  = '0;
        s_last  = '0;
        s_user  = '0;
        m_ready = 1'b1;
        clearLogs();

        // Reset state, with requests applied during reset
        repeat (3) @(negedge clk);
        s_valid = 4'b1010;
        s_last  = 4'b1010;
        #1;
        checkOutput("reset_m_valid", 64'(m_valid), 64'(0));
        checkOutput("reset_m_data", m_data, 64'(0));
        checkOutput("reset_m_last_user_sel", 64'({m_last, m_user, m_sel}), 64'(0));
        checkOutput("reset_s_ready", 64'(s_ready), 64'(0));
        checkOutput("reset_ack", 64'(arb_acknowledge), 64'(0));
        checkOutput("reset_request", 64'(arb_request), 64'(4'b1010));
        s_valid = '0;
        s_last  = '0;
        rst     = 1'b0;
        repeat (2) @(negedge clk);

        // Single-beat packets on ports 1 and 3: rotation starts at port 0
        clearLogs();
        loadPort(1, 64'h10, 2, 1, -1, 0);
        loadPort(3, 64'h30, 2, 1, -1, 0);
        applyStimulus(8);
        checkStream("single", '{1, 3, 1, 3});
        checkAckCycles("single", '{1, 2, 3, 4});
        checkOutput("single_acc_cyc_last", 64'(acc_cyc.size() > 0 ? acc_cyc[acc_cyc.size()-1] : -1), 64'(4));
        checkInvariants("single");

        // Single 3-beat packet on port 2
        clearLogs();
        loadPort(2, 64'hA0, 3, 3, -1, 0);
        applyStimulus(8);
        checkStream("port2", '{2, 2, 2});
        checkOutput("port2_first_out_cyc", 64'(out_cyc.size() > 0 ? out_cyc[0] : -1), 64'(2));
        checkAckCycles("port2", '{3});
        checkOutput("port2_ack_port", 64'(ack_port.size() > 0 ? ack_port[0] : -1), 64'(2));
        checkInvariants("port2");

        // Round robin across all ports, 2-beat packets, back to back
        clearLogs();
        for (int p = 0; p < PORTS; p++) loadPort(p, 64'h1000 + 64'(p * 16), 2, 2, -1, 0);
        applyStimulus(14);
        checkStream("rr", '{3, 3, 0, 0, 1, 1, 2, 2});
        checkOutput("rr_first_out_cyc", 64'(out_cyc.size() > 0 ? out_cyc[0] : -1), 64'(2));
        checkOutput("rr_last_out_cyc", 64'(out_cyc.size() == 8 ? out_cyc[7] : -1), 64'(9));
        checkAckCycles("rr", '{2, 4, 6, 8});
        checkInvariants("rr");

        // Backpressure on an 8-beat packet from port 1
        clearLogs();
        loadPort(1, 64'h2000, 8, 8, -1, 0);
        m_ready_pat = '{1, 1, 1, 0, 0, 1, 0, 1};
        applyStimulus(16);
        checkStream("bp", '{1, 1, 1, 1, 1, 1, 1, 1});
        checkOutput("bp_extra_after_fall", 64'(max_extra), 64'(1));
        checkOutput("bp_last_out_cyc", 64'(out_cyc.size() == 8 ? out_cyc[7] : -1), 64'(12));
        checkAckCycles("bp", '{11});
        checkInvariants("bp");

        // Port 0 bubbles mid-packet while port 1 waits
        clearLogs();
        loadPort(0, 64'h3000, 3, 3, 2, 3);
        loadPort(1, 64'h3100, 2, 2, -1, 0);
        applyStimulus(14);
        checkStream("bubble", '{0, 0, 0, 1, 1});
        checkOutput("bubble_port1_first_ready", 64'(first_ready[1]), 64'(7));
        checkAckCycles("bubble", '{6, 8});
        checkInvariants("bubble");

        // Reset after two beats of a stalled 5-beat packet
        clearLogs();
        loadPort(0, 64'h4000, 5, 5, -1, 0);
        m_ready_pat = '{0, 0, 0};
        applyStimulus(3);
        checkOutput("rstmid_accepted_before", 64'(acc_port.size()), 64'(2));
        rst     = 1'b1;
        m_ready = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rstmid_m_valid", 64'(m_valid), 64'(0));
        checkOutput("rstmid_s_ready", 64'(s_ready), 64'(0));
        checkOutput("rstmid_m_sel", 64'(m_sel), 64'(0));
        rst = 1'b0;
        clearLogs();
        @(negedge clk);
        loadPort(3, 64'h5000, 2, 2, -1, 0);
        applyStimulus(8);
        checkStream("rstmid_after", '{3, 3});
        checkInvariants("rstmid_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
